// File: rtl/spi_responder_pkg.sv
// ============================================================================
// Module   : spi_responder_pkg
// Brief    : Shared types and command/address constants for spi_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WDATA  = 3'd3,
      ST_RDATA  = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [3:0] ID_ADDR   = 4'hF;

endpackage

`default_nettype wire

// File: rtl/spi_pin_sync.sv
// ============================================================================
// Module   : spi_pin_sync
// Brief    : Multi-flop synchroniser with registered rise/fall edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_pin_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   logic              r_rise;
   logic              r_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], din};
         r_prev <= r_sync[STAGES-1];
         r_rise <= r_sync[STAGES-1] & ~r_prev;
         r_fall <= ~r_sync[STAGES-1] & r_prev;
      end
   end

   assign level = r_sync[STAGES-1];
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/spi_responder.sv
// ============================================================================
// Module   : spi_responder
// Brief    : SPI mode-0 target exposing a 16-byte register file (0xF = ID).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_responder
   import spi_responder_pkg::*;
#(
   parameter logic [7:0] ID          = 8'h5A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       SCK,
   input  logic       MOSI,
   input  logic       nSS,
   output logic       MISO,
   output logic       MISO_OE,
   input  logic [3:0] RADDR,
   output logic [7:0] RDATA,
   output logic       WSTB,
   output logic [3:0] WADDR,
   output logic [7:0] WDATA,
   output logic       BUSY
);

   logic w_sck_rise, w_sck_fall, w_nss_level, w_nss_rise, w_nss_fall, w_mosi;
   logic w_unused_sck_level, w_unused_mosi_rise, w_unused_mosi_fall;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk(CLK), .rst_n(nRESET), .din(SCK),
      .level(w_unused_sck_level), .rise(w_sck_rise), .fall(w_sck_fall));

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_nss_sync (
      .clk(CLK), .rst_n(nRESET), .din(nSS),
      .level(w_nss_level), .rise(w_nss_rise), .fall(w_nss_fall));

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
      .clk(CLK), .rst_n(nRESET), .din(MOSI),
      .level(w_mosi), .rise(w_unused_mosi_rise), .fall(w_unused_mosi_fall));

   // The nSS pipeline resets to "high"; a low pin would then look like a fresh
   // fall. Frames are only accepted once the pipeline holds real pin samples.
   logic [SYNC_STAGES+1:0] r_warm;
   logic                   w_start;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) r_warm <= '0;
      else         r_warm <= {r_warm[SYNC_STAGES:0], 1'b1};
   end

   assign w_start = w_nss_fall & r_warm[SYNC_STAGES+1];

   state_t      r_state, w_next;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_shift_in, r_cmd, r_shift_out;
   logic [3:0]  r_addr;
   logic        r_load_pend;
   logic        r_wstb;
   logic [3:0]  r_waddr;
   logic [7:0]  r_wdata, r_rdata;
   logic [7:0]  r_regs [15];
   logic [7:0]  w_rd_spi, w_rd_loc, w_byte;
   logic        w_sck_r, w_sck_f, w_last, w_we;

   assign w_sck_r = w_sck_rise & ~w_nss_level;
   assign w_sck_f = w_sck_fall & ~w_nss_level;
   assign w_byte  = {r_shift_in[6:0], w_mosi};
   assign w_last  = (r_bitcnt == 3'd7);
   assign w_we    = w_sck_r & w_last & (r_state == ST_WDATA) & (r_addr != ID_ADDR);

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_nss_rise) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_CMD;
            ST_CMD:   if (w_sck_r && w_last) w_next = ST_ADDR;
            ST_ADDR:
               if (w_sck_r && w_last) begin
                  if (r_cmd == CMD_WRITE)     w_next = ST_WDATA;
                  else if (r_cmd == CMD_READ) w_next = ST_RDATA;
                  else                        w_next = ST_IGNORE;
               end
            default:  w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_bitcnt    <= 3'd0;
         r_shift_in  <= 8'h00;
         r_cmd       <= 8'h00;
         r_shift_out <= 8'h00;
         r_addr      <= 4'h0;
         r_load_pend <= 1'b0;
         r_wstb      <= 1'b0;
         r_waddr     <= 4'h0;
         r_wdata     <= 8'h00;
      end else begin
         r_wstb <= 1'b0;
         if (w_start) begin
            r_bitcnt    <= 3'd0;
            r_load_pend <= 1'b0;
            r_shift_out <= 8'h00;
         end
         if (w_sck_r && r_state != ST_IDLE && r_state != ST_IGNORE) begin
            r_shift_in <= w_byte;
            r_bitcnt   <= r_bitcnt + 3'd1;
            if (w_last) begin
               case (r_state)
                  ST_CMD:   r_cmd <= w_byte;
                  ST_ADDR: begin
                     r_addr      <= w_byte[3:0];
                     r_load_pend <= (r_cmd == CMD_READ);
                  end
                  ST_WDATA: begin
                     if (r_addr != ID_ADDR) begin
                        r_wstb  <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= w_byte;
                     end
                     r_addr <= r_addr + 4'd1;
                  end
                  ST_RDATA: r_load_pend <= 1'b1;
                  default:  r_load_pend <= r_load_pend;
               endcase
            end
         end
         // Falling edge either loads the next byte or shifts the current one.
         if (w_sck_f && r_state == ST_RDATA) begin
            if (r_load_pend) begin
               r_shift_out <= w_rd_spi;
               r_addr      <= r_addr + 4'd1;
               r_load_pend <= 1'b0;
            end else begin
               r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         for (int i = 0; i < 15; i++) r_regs[i] <= 8'h00;
         r_rdata <= 8'h00;
      end else begin
         for (int i = 0; i < 15; i++) begin
            if (w_we && r_addr == 4'(i)) r_regs[i] <= w_byte;
         end
         r_rdata <= w_rd_loc;
      end
   end

   always_comb begin
      w_rd_spi = ID;
      w_rd_loc = ID;
      for (int i = 0; i < 15; i++) begin
         if (r_addr == 4'(i)) w_rd_spi = r_regs[i];
         if (RADDR  == 4'(i)) w_rd_loc = r_regs[i];
      end
   end

   assign MISO    = (r_state == ST_RDATA) & r_shift_out[7];
   assign MISO_OE = ~w_nss_level;
   assign BUSY    = ~w_nss_level;
   assign WSTB    = r_wstb;
   assign WADDR   = r_waddr;
   assign WDATA   = r_wdata;
   assign RDATA   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_spi_responder.sv
// ============================================================================
// Module   : tb_spi_responder
// Brief    : Directed self-checking bench for spi_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_responder;

   localparam int HP = 8;

   logic       CLK = 1'b0;
   logic       nRESET, SCK, MOSI, nSS;
   logic       MISO, MISO_OE, WSTB, BUSY;
   logic [3:0] RADDR, WADDR;
   logic [7:0] RDATA, WDATA;

   int vectors     = 0;
   int miscompares = 0;
   int wstb_cnt    = 0;
   int miso_hi     = 0;

   spi_responder #(.ID(8'h5A), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
      .MISO(MISO), .MISO_OE(MISO_OE), .RADDR(RADDR), .RDATA(RDATA),
      .WSTB(WSTB), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY));

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (nRESET === 1'b1) begin
         if (WSTB === 1'b1) wstb_cnt++;
         if (MISO === 1'b1) miso_hi++;
      end
   end

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         MOSI = tx[i];
         repeat (HP) @(negedge CLK);
         rx[i] = MISO;
         SCK = 1'b1;
         repeat (HP) @(negedge CLK);
         SCK = 1'b0;
      end
   endtask

   task automatic begin_frame();
      nSS = 1'b0;
      repeat (HP) @(negedge CLK);
   endtask

   task automatic end_frame();
      repeat (HP) @(negedge CLK);
      nSS = 1'b1;
      repeat (HP) @(negedge CLK);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      vectors += 7;
      if (MISO !== 1'b0)    begin miscompares++; $display("FAIL rst_miso got %b want 0", MISO); end
      if (MISO_OE !== 1'b0) begin miscompares++; $display("FAIL rst_oe got %b want 0", MISO_OE); end
      if (WSTB !== 1'b0)    begin miscompares++; $display("FAIL rst_wstb got %b want 0", WSTB); end
      if (WADDR !== 4'h0)   begin miscompares++; $display("FAIL rst_waddr got %h want 0", WADDR); end
      if (WDATA !== 8'h00)  begin miscompares++; $display("FAIL rst_wdata got %h want 00", WDATA); end
      if (RDATA !== 8'h00)  begin miscompares++; $display("FAIL rst_rdata got %h want 00", RDATA); end
      if (BUSY !== 1'b0)    begin miscompares++; $display("FAIL rst_busy got %b want 0", BUSY); end
      nRESET = 1'b1;
      repeat (HP) @(negedge CLK);
   endtask

   task automatic test_write();
      logic [7:0] rx;
      int w0;
      w0 = wstb_cnt;
      begin_frame();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h05, 8, rx);
      spi_xfer(8'hA5, 8, rx);
      end_frame();
      vectors += 4;
      if (wstb_cnt - w0 !== 1) begin miscompares++; $display("FAIL wr_wstb_count got %0d want 1", wstb_cnt - w0); end
      if (WADDR !== 4'h5)      begin miscompares++; $display("FAIL wr_waddr got %h want 5", WADDR); end
      if (WDATA !== 8'hA5)     begin miscompares++; $display("FAIL wr_wdata got %h want a5", WDATA); end
      RADDR = 4'h5;
      @(negedge CLK);
      if (RDATA !== 8'hA5)     begin miscompares++; $display("FAIL wr_rdata got %h want a5", RDATA); end
   endtask

   task automatic test_burst();
      logic [7:0] rx;
      int w0;
      w0 = wstb_cnt;
      begin_frame();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h0E, 8, rx);
      spi_xfer(8'h11, 8, rx);
      spi_xfer(8'h22, 8, rx);
      spi_xfer(8'h33, 8, rx);
      end_frame();
      vectors += 6;
      if (wstb_cnt - w0 !== 2) begin miscompares++; $display("FAIL burst_wstb_count got %0d want 2", wstb_cnt - w0); end
      if (WADDR !== 4'h0)      begin miscompares++; $display("FAIL burst_waddr got %h want 0", WADDR); end
      if (WDATA !== 8'h33)     begin miscompares++; $display("FAIL burst_wdata got %h want 33", WDATA); end
      RADDR = 4'hE; @(negedge CLK);
      if (RDATA !== 8'h11)     begin miscompares++; $display("FAIL burst_reg_e got %h want 11", RDATA); end
      RADDR = 4'h0; @(negedge CLK);
      if (RDATA !== 8'h33)     begin miscompares++; $display("FAIL burst_reg_0 got %h want 33", RDATA); end
      RADDR = 4'hF; @(negedge CLK);
      if (RDATA !== 8'h5A)     begin miscompares++; $display("FAIL burst_reg_f got %h want 5a", RDATA); end
   endtask

   task automatic test_read_wrap();
      logic [7:0] rx;
      begin_frame();
      vectors += 4;
      if (MISO_OE !== 1'b1) begin miscompares++; $display("FAIL rd_oe_in_frame got %b want 1", MISO_OE); end
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h0F, 8, rx);
      spi_xfer(8'h00, 8, rx);
      if (rx !== 8'h5A) begin miscompares++; $display("FAIL rd_byte_id got %h want 5a", rx); end
      spi_xfer(8'h00, 8, rx);
      if (rx !== 8'h33) begin miscompares++; $display("FAIL rd_byte_wrap got %h want 33", rx); end
      end_frame();
      if (MISO_OE !== 1'b0) begin miscompares++; $display("FAIL rd_oe_after got %b want 0", MISO_OE); end
   endtask

   task automatic test_partial();
      logic [7:0] rx;
      int w0;
      begin_frame();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h3C, 8, rx);
      end_frame();
      w0 = wstb_cnt;
      begin_frame();
      spi_xfer(8'h02, 8, rx);
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'hFF, 5, rx);
      end_frame();
      vectors += 4;
      if (wstb_cnt - w0 !== 0) begin miscompares++; $display("FAIL part_wstb got %0d want 0", wstb_cnt - w0); end
      if (BUSY !== 1'b0)       begin miscompares++; $display("FAIL part_busy got %b want 0", BUSY); end
      RADDR = 4'h3; @(negedge CLK);
      if (RDATA !== 8'h3C)     begin miscompares++; $display("FAIL part_reg3 got %h want 3c", RDATA); end
      begin_frame();
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h00, 8, rx);
      end_frame();
      if (rx !== 8'h3C)        begin miscompares++; $display("FAIL part_readback got %h want 3c", rx); end
   endtask

   task automatic test_ignore();
      logic [7:0] rx;
      int w0, m0;
      w0 = wstb_cnt;
      m0 = miso_hi;
      begin_frame();
      spi_xfer(8'h7E, 8, rx);
      spi_xfer(8'h01, 8, rx);
      spi_xfer(8'h55, 8, rx);
      end_frame();
      vectors += 3;
      if (miso_hi - m0 !== 0)  begin miscompares++; $display("FAIL ign_miso got %0d want 0", miso_hi - m0); end
      if (wstb_cnt - w0 !== 0) begin miscompares++; $display("FAIL ign_wstb got %0d want 0", wstb_cnt - w0); end
      RADDR = 4'h1; @(negedge CLK);
      if (RDATA !== 8'h00)     begin miscompares++; $display("FAIL ign_reg1 got %h want 00", RDATA); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx;
      int m0, w0;
      begin_frame();
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h05, 8, rx);
      spi_xfer(8'h00, 3, rx);
      nRESET = 1'b0;
      repeat (2) @(negedge CLK);
      vectors += 7;
      if (MISO !== 1'b0)    begin miscompares++; $display("FAIL mid_miso got %b want 0", MISO); end
      if (MISO_OE !== 1'b0) begin miscompares++; $display("FAIL mid_oe got %b want 0", MISO_OE); end
      if (WSTB !== 1'b0)    begin miscompares++; $display("FAIL mid_wstb got %b want 0", WSTB); end
      if (WADDR !== 4'h0)   begin miscompares++; $display("FAIL mid_waddr got %h want 0", WADDR); end
      if (WDATA !== 8'h00)  begin miscompares++; $display("FAIL mid_wdata got %h want 00", WDATA); end
      if (RDATA !== 8'h00)  begin miscompares++; $display("FAIL mid_rdata got %h want 00", RDATA); end
      if (BUSY !== 1'b0)    begin miscompares++; $display("FAIL mid_busy got %b want 0", BUSY); end
      nRESET = 1'b1;
      m0 = miso_hi;
      w0 = wstb_cnt;
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h0F, 8, rx);
      spi_xfer(8'h00, 8, rx);
      vectors += 4;
      if (miso_hi - m0 !== 0 || rx !== 8'h00)
         begin miscompares++; $display("FAIL mid_no_resume got miso_hi=%0d rx=%h want 0/00", miso_hi - m0, rx); end
      if (wstb_cnt - w0 !== 0) begin miscompares++; $display("FAIL mid_wstb_after got %0d want 0", wstb_cnt - w0); end
      end_frame();
      RADDR = 4'h5; @(negedge CLK);
      if (RDATA !== 8'h00) begin miscompares++; $display("FAIL mid_reg5_cleared got %h want 00", RDATA); end
      begin_frame();
      spi_xfer(8'h03, 8, rx);
      spi_xfer(8'h0F, 8, rx);
      spi_xfer(8'h00, 8, rx);
      end_frame();
      if (rx !== 8'h5A) begin miscompares++; $display("FAIL mid_recover got %h want 5a", rx); end
   endtask

   initial begin
      nRESET = 1'b0;
      SCK    = 1'b0;
      MOSI   = 1'b0;
      nSS    = 1'b1;
      RADDR  = 4'h0;
      test_reset();
      test_write();
      test_burst();
      test_read_wrap();
      test_partial();
      test_ignore();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_responder.md
# spi_responder

SPI target (mode 0) that answers the bit-banged SPI master on the Gigatron extension board: it receives SCK/MOSI/nSS on one of the board's SPI selects and drives MISO back. It exposes a 16-byte register file to the SPI master and a local read port plus write strobe to the surrounding logic. It is used both as an on-board peripheral and as the bench partner for the SPI master path. All SPI pins are asynchronous to CLK and are synchronised inside the block.

## Interface
- ID, 8'h5A: value returned by read-only register 0xF.
- SYNC_STAGES, 2: synchroniser depth on SCK, MOSI and nSS (≥2).
- CLK  in  1  system clock; all state changes on posedge.
- nRESET  in  1  reset, asynchronous and active-low.
- SCK  in  1  SPI clock from master, async, idle low.
- MOSI  in  1  SPI data from master, async.
- nSS  in  1  SPI select from master, async, active-low.
- MISO  out  1  SPI data to master.
- MISO_OE  out  1  MISO drive enable; the pad is tri-stated when low.
- RADDR  in  4  local read address.
- RDATA  out  8  local read data, registered.
- WSTB  out  1  one-CLK pulse per committed SPI write.
- WADDR  out  4  address of the last committed write.
- WDATA  out  8  data of the last committed write.
- BUSY  out  1  high while synchronised nSS is low.

## Operation
- Frame is nSS low. Byte 0 is CMD, byte 1 is ADDR (only bits [3:0] used), then data bytes. All bytes are MSB first.
- CMD 0x02 is a burst write: each completed data byte is written to reg[addr]. The write raises WSTB with WADDR/WDATA, and addr then increments.
- CMD 0x03 is a burst read: reg[addr] is shifted out, and addr increments after each byte is loaded.
- Any other CMD enters IGNORE: MISO=0, no writes until nSS rises.
- Address wraps 4'hF -> 4'h0.
- Register 0xF reads ID. SPI writes to it are discarded, but addr still increments and WSTB is not pulsed.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - Synchronised nSS fall: IDLE -> CMD, with bit counter cleared.
  - 8th bit of CMD: CMD -> ADDR.
  - 8th bit of ADDR: ADDR -> WDATA, RDATA, or IGNORE per CMD.
  - WDATA and RDATA stay in place byte after byte.
  - Synchronised nSS rise in any state -> IDLE.
- Sampling: MOSI is sampled on the rising SCK edge. MISO shift register updates on the falling SCK edge.
- In RDATA, the shift register loads reg[addr] on the falling SCK edge that follows the 8th rising edge of ADDR, or of the previous data byte. Bit 7 is driven immediately on that load.
- MISO is 0 in CMD and ADDR.
- MISO_OE equals !nSS_sync.
- Arithmetic: 3-bit bit counter wraps at 8. 4-bit address counter, modulo 16.

## Timing
- Pin-to-detected-edge latency is SYNC_STAGES+1 CLK.
- The master must hold SCK high and low for ≥ SYNC_STAGES+3 CLK each. nSS setup to the first SCK rise and hold after the last SCK fall are each ≥ SYNC_STAGES+3 CLK.
- WSTB asserts on the CLK after the detected 8th rising edge of a data byte.
- The register write occurs on the same CLK edge that asserts WSTB. WADDR/WDATA are held until the next write.
- RDATA = reg[RADDR] one CLK after RADDR is presented.
- If the read and a same-address SPI write hit the same cycle, RDATA shows the old value that cycle and the new value the next cycle.
- nSS rising together with a detected SCK edge in the same CLK: nSS wins, the edge is ignored, and a partial byte is discarded with no write.
- A detected SCK edge while nSS_sync is high is ignored.
- Reset values:
  - MISO=0, MISO_OE=0, WSTB=0, WADDR=0, WDATA=0, RDATA=0, BUSY=0.
  - All registers 0, FSM=IDLE, counters 0.
  - Synchroniser flops: nSS=1, SCK=0, MOSI=0.
- Reset asserted mid-frame aborts immediately. After release, the block waits for a fresh nSS fall and does not resume the old frame, even if nSS is already low.

## Structure
- Package spi_responder_pkg: state enum, CMD_WRITE=8'h02, CMD_READ=8'h03, ID_ADDR=4'hF.
- Sub-module spi_pin_sync: SYNC_STAGES flops plus edge register, with outputs level, rise and fall. It is instantiated for SCK and nSS. MOSI uses its level only.
- Register file: 15×8 flops plus the ID constant. No RAM inference is needed.

## Test plan
- Write frame 02 05 A5, nSS high → reg[5]=A5; a single WSTB with WADDR=5, WDATA=A5; RADDR=5 then gives RDATA=A5 one CLK later.
- Read frame 03 0F xx xx → MISO bytes 5A then reg[0]. The address wrap is exercised and MISO_OE is high only during the frame.
- Burst write 02 0E 11 22 33 → reg[E]=11, reg[0]=33; reg[F] still reads 5A; exactly two WSTB pulses.
- Write 02 03 then 5 bits of FF, then nSS rise → reg[3] unchanged, no WSTB, FSM returns to IDLE. A following read 03 03 returns the old value.
- CMD 7E 01 55 → MISO stays 0, no WSTB, no register change.
- Pulse nRESET low mid-read with nSS held low → all outputs at reset values. Clocking SCK afterwards produces no MISO activity until nSS toggles high then low.
